// File: rtl/merge_defs.sv
// Shared definitions for the 2:1 stream merger.
// Source IDs, FSM encodings and default data width.
package merge_defs;

    localparam int WIDTH_DEF = 8;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux_2x1.sv
// Two-way selector, mirror of demux_1x2.
// Reused for both the data word and the source tag.
module mux_2x1 #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    output logic [W-1:0] y
);

    assign y = sel ? i1 : i0;

endmodule

// File: rtl/stream_merge_2x1.sv
// Round-robin 2:1 valid/ready merger with a registered,
// source-tagged output stage.
module stream_merge_2x1
    import merge_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    state_t           state;
    logic             pri;
    logic             load;
    logic             gnt_vld;
    logic             gnt;
    logic [WIDTH-1:0] mux_data;
    logic             mux_src;

    assign out_valid = (state == FULL);
    assign load      = ~out_valid | out_ready;

    // Grant is only ever offered when the output stage can take it.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = SRC0;
        if (load && !rst) begin
            unique case (1'b1)
                (in0_valid && !in1_valid): begin
                    gnt_vld = 1'b1;
                    gnt     = SRC0;
                end
                (!in0_valid && in1_valid): begin
                    gnt_vld = 1'b1;
                    gnt     = SRC1;
                end
                (in0_valid && in1_valid): begin
                    gnt_vld = 1'b1;
                    gnt     = pri;
                end
                default: ;
            endcase
        end
    end

    assign in0_ready = gnt_vld & (gnt == SRC0);
    assign in1_ready = gnt_vld & (gnt == SRC1);

    mux_2x1 #(.W(WIDTH)) u_data_mux (
        .sel (gnt),
        .i0  (in0_data),
        .i1  (in1_data),
        .y   (mux_data)
    );

    mux_2x1 #(.W(1)) u_src_mux (
        .sel (gnt),
        .i0  (SRC0),
        .i1  (SRC1),
        .y   (mux_src)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_src  <= SRC0;
            pri      <= SRC0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (gnt_vld) begin
                        state    <= FULL;
                        out_data <= mux_data;
                        out_src  <= mux_src;
                        pri      <= ~gnt;
                    end
                end
                FULL: begin
                    if (gnt_vld) begin
                        out_data <= mux_data;
                        out_src  <= mux_src;
                        pri      <= ~gnt;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_merge_2x1.sv
// Scoreboard bench for stream_merge_2x1: directed scenarios
// followed by a random run with per-source ordering checks.
module tb_stream_merge_2x1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0_valid;
    logic [7:0] in0_data;
    logic       in0_ready;
    logic       in1_valid;
    logic [7:0] in1_data;
    logic       in1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src;
    logic       out_ready;

    int checks = 0;
    int errors = 0;
    bit rnd_mode = 1'b0;

    logic [8:0] exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    stream_merge_2x1 dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake is scored against the model.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (!rnd_mode) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_word: got %0d/0x%0h expected none",
                             out_src, out_data);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({out_src, out_data} !== e) begin
                        errors++;
                        $display("FAIL out_word: got %0d/0x%0h expected %0d/0x%0h",
                                 out_src, out_data, e[8], e[7:0]);
                    end
                end
            end else if (out_src == 1'b0) begin
                if (q0.size() == 0 || q0[0] !== out_data) begin
                    errors++;
                    $display("FAIL rnd_src0: got 0x%0h expected 0x%0h",
                             out_data, (q0.size() != 0) ? q0[0] : 8'hxx);
                end
                if (q0.size() != 0) void'(q0.pop_front());
            end else begin
                if (q1.size() == 0 || q1[0] !== out_data) begin
                    errors++;
                    $display("FAIL rnd_src1: got 0x%0h expected 0x%0h",
                             out_data, (q1.size() != 0) ? q1[0] : 8'hxx);
                end
                if (q1.size() != 0) void'(q1.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic a0, a1;
        rst       = 1'b1;
        out_ready = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 8'hAA;
        in1_valid = 1'b1;
        in1_data  = 8'h55;

        // Reset with both inputs requesting
        out_ready = 1'b1;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_pri", dut.pri, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in0_ready", in0_ready, 0);
        check("rst_in1_ready", in1_ready, 0);
        step();
        check("rst2_out_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        check("rel_in0_ready", in0_ready, 1);
        check("rel_in1_ready", in1_ready, 0);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        step();
        check("rel_no_xfer", out_valid, 0);

        // Single source on in1
        for (int i = 1; i <= 4; i++) exp_q.push_back({1'b1, 8'(i)});
        for (int i = 1; i <= 4; i++) begin
            in1_valid = 1'b1;
            in1_data  = 8'(i);
            step();
            check("single_data", out_data, i);
            check("single_src", out_src, 1);
        end
        in1_valid = 1'b0;
        step();
        step();
        check("single_pri", dut.pri, 0);
        check("single_drained", exp_q.size(), 0);

        // Continuous contention: strict alternation
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h21});
        exp_q.push_back({1'b0, 8'h12});
        exp_q.push_back({1'b1, 8'h22});
        in0_valid = 1'b1;
        in0_data  = 8'h10;
        in1_valid = 1'b1;
        in1_data  = 8'h20;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a0 = in0_ready;
            a1 = in1_ready;
            check("cont_one_ready", {31'b0, a0 ^ a1}, 1);
            step();
            if (a0) in0_data = in0_data + 8'd1;
            if (a1) in1_data = in1_data + 8'd1;
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        step();
        step();
        check("cont_drained", exp_q.size(), 0);

        // Backpressure holds the word and blocks in1
        exp_q.push_back({1'b0, 8'h3C});
        exp_q.push_back({1'b1, 8'h7E});
        in0_valid = 1'b1;
        in0_data  = 8'h3C;
        out_ready = 1'b1;
        step();
        in0_valid = 1'b0;
        out_ready = 1'b0;
        in1_valid = 1'b1;
        in1_data  = 8'h7E;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_data", out_data, 8'h3C);
            check("bp_src", out_src, 0);
            check("bp_in1_ready", in1_ready, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in1_ready, 1);
        step();
        in1_valid = 1'b0;
        check("bp_new_data", out_data, 8'h7E);
        check("bp_new_src", out_src, 1);

        // Drain to empty with no inputs
        exp_q.push_back({1'b0, 8'h99});
        in0_valid = 1'b1;
        in0_data  = 8'h99;
        step();
        in0_valid = 1'b0;
        check("drain_full", out_valid, 1);
        check("drain_data", out_data, 8'h99);
        step();
        check("drain_empty", out_valid, 0);
        step();
        check("drain_stay_empty", out_valid, 0);
        check("drain_q", exp_q.size(), 0);

        // Reset mid-stream discards the held word
        out_ready = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 8'h42;
        step();
        in0_valid = 1'b0;
        check("mid_full", out_valid, 1);
        check("mid_data", out_data, 8'h42);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        out_ready = 1'b1;
        step();
        step();
        check("mid_no_word", out_valid, 0);

        // Random traffic: per-source order, no loss or duplication
        rnd_mode = 1'b1;
        a0 = 1'b0;
        a1 = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (!in0_valid || a0) begin
                in0_valid = ($urandom_range(0, 2) != 0);
                in0_data  = 8'($urandom);
                if (in0_valid) q0.push_back(in0_data);
            end
            if (!in1_valid || a1) begin
                in1_valid = ($urandom_range(0, 2) != 0);
                in1_data  = 8'($urandom);
                if (in1_valid) q1.push_back(in1_data);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            a0 = in0_valid & in0_ready;
            a1 = in1_valid & in1_ready;
            step();
        end
        if (!a0 && in0_valid) begin
            for (int i = 0; i < 20 && !in0_ready; i++) step();
            @(negedge clk);
            step();
        end
        in0_valid = 1'b0;
        if (!a1 && in1_valid) begin
            out_ready = 1'b1;
            for (int i = 0; i < 20 && !in1_ready; i++) step();
            @(negedge clk);
            step();
        end
        in1_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("rnd_q0_empty", q0.size(), 0);
        check("rnd_q1_empty", q1.size(), 0);
        check("rnd_out_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
